// File: rtl/wave_period_meter.sv
// wave_period_meter: hysteresis crossing detector that measures waveform period and
// peak-to-peak amplitude between consecutive rising crossings.
// Latency: period/amp_pp/period_valid are registered one cycle after the closing crossing.
// Backpressure: none; samples are qualified by sample_valid only, outputs are pulses.
//
// Ports:
//   clk, reset         - single rising-edge clock, synchronous active-high reset
//   sample[7:0]        - unsigned waveform sample, accepted when sample_valid=1
//   period[31:0]       - last measured period in clk cycles
//   amp_pp[7:0]        - max - min of accepted samples over the measured period
//   period_valid       - one-cycle pulse when period/amp_pp update
//   locked             - high from the first period_valid until a timeout
//   signal_lost        - sticky timeout flag, cleared by the next period_valid
//
// Optional feature macro: PERIOD_AVG_EN
//   When defined, period is the mean of the last 4 raw periods and period_valid
//   only pulses once 4 raw measurements are in the history.

module wave_period_meter #(
  parameter logic [7:0]  THRESH_HI = 8'd140,
  parameter logic [7:0]  THRESH_LO = 8'd100,
  parameter logic [31:0] TIMEOUT   = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  sample,
  input  logic        sample_valid,
  output logic [31:0] period,
  output logic [7:0]  amp_pp,
  output logic        period_valid,
  output logic        locked,
  output logic        signal_lost
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ARMED = 2'd1,
    HIGH  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // A reference crossing is held once any crossing has been seen since
  // reset/timeout; only then does a crossing close a measurement.
  logic        ref_held;
  // Cycles since the reference crossing: at a clock edge it reads (edge - A).
  logic [31:0] cnt;
  logic [7:0]  max_q;
  logic [7:0]  min_q;

  logic        crossing;
  logic        measure;
  logic        timeout_hit;
  logic [7:0]  trk_max;
  logic [7:0]  trk_min;
  logic [7:0]  amp_now;

  // Emit decides whether this measurement is published; period_new is the
  // value published (raw or averaged).
  logic        emit;
  logic [31:0] period_new;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    if (timeout_hit) begin
      state_nxt = HUNT;
    end else if (sample_valid) begin
      case (state)
        HUNT: begin
          if (sample <= THRESH_LO) state_nxt = ARMED;
        end
        ARMED: begin
          if (sample >= THRESH_HI) state_nxt = HIGH;
        end
        HIGH: begin
          if (sample <= THRESH_LO) state_nxt = ARMED;
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    crossing    = sample_valid && (state == ARMED) && (sample >= THRESH_HI);
    measure     = crossing && ref_held;
    // A crossing landing on the timeout cycle takes priority, so the timeout
    // is suppressed and the measurement reports period == TIMEOUT.
    // HUNT without a reference is idle and never times out.
    timeout_hit = !crossing && (cnt == TIMEOUT) && ((state != HUNT) || ref_held);
  end

  // Running extremes including the current sample, so the closing crossing's
  // own sample is part of the amplitude it reports.
  always_comb begin
    trk_max = (sample > max_q) ? sample : max_q;
    trk_min = (sample < min_q) ? sample : min_q;
    amp_now = trk_max - trk_min;
  end

`ifdef PERIOD_AVG_EN
  // ---------------------------------------------------------------------------
  // Period averaging over the last 4 raw measurements
  // ---------------------------------------------------------------------------
  logic [2:0][31:0] hist;
  logic [1:0]       hist_cnt;
  logic [33:0]      avg_sum;

  always_comb begin
    // Four 32-bit terms fit in 34 bits, so the sum cannot overflow.
    avg_sum    = {2'b00, cnt} + {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]};
    emit       = measure && (hist_cnt == 2'd3);
    period_new = 32'(avg_sum >> 2);
  end

  always_ff @(posedge clk) begin
    if (reset || timeout_hit) begin
      hist     <= '0;
      hist_cnt <= 2'd0;
    end else if (measure) begin
      hist <= {hist[1:0], cnt};
      if (hist_cnt != 2'd3) begin
        hist_cnt <= hist_cnt + 2'd1;
      end
    end
  end
`else
  always_comb begin
    emit       = measure;
    period_new = cnt;
  end
`endif

  // ---------------------------------------------------------------------------
  // Interval counter, reference flag and min/max trackers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= 32'd0;
      ref_held <= 1'b0;
      max_q    <= 8'h00;
      min_q    <= 8'hFF;
    end else begin
      // Loading 1 at the crossing makes cnt read exactly B - A at crossing B.
      if (crossing) begin
        cnt <= 32'd1;
      end else if (timeout_hit) begin
        cnt <= 32'd0;
      end else if (cnt != 32'hFFFF_FFFF) begin
        cnt <= cnt + 32'd1;
      end

      if (crossing) begin
        ref_held <= 1'b1;
      end else if (timeout_hit) begin
        ref_held <= 1'b0;
      end

      // Every crossing restarts the trackers with its own sample.
      if (crossing) begin
        max_q <= sample;
        min_q <= sample;
      end else if (sample_valid) begin
        max_q <= trk_max;
        min_q <= trk_min;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Published results and status flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      period       <= 32'd0;
      amp_pp       <= 8'd0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      signal_lost  <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (emit) begin
        period       <= period_new;
        amp_pp       <= amp_now;
        period_valid <= 1'b1;
        locked       <= 1'b1;
        signal_lost  <= 1'b0;
      end else if (timeout_hit) begin
        // period/amp_pp keep their last published values.
        locked      <= 1'b0;
        signal_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wave_period_meter.sv
// tb_wave_period_meter: directed stimulus for wave_period_meter with a queue
// scoreboard; the stimulus pushes expected pulses, a negedge monitor pops them.
// Expected staircase period is 16 steps x 64 cycles = 1024, amplitude 240 - 0.

module tb_wave_period_meter;

  localparam int TO = 2000;
`ifdef PERIOD_AVG_EN
  localparam int NEED = 4;
`else
  localparam int NEED = 1;
`endif

  typedef struct packed {
    logic [31:0] period;
    logic [7:0]  amp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  sample;
  logic        sample_valid;
  logic [31:0] period;
  logic [7:0]  amp_pp;
  logic        period_valid;
  logic        locked;
  logic        signal_lost;

  exp_t expq[$];
  int   total = 0;
  int   bad = 0;
  int   pulses = 0;
  int   cyc = 0;
  int   chain = 0;
  int   last_cross = 0;

  always #5 clk = ~clk;

  wave_period_meter #(
    .THRESH_HI(8'd140),
    .THRESH_LO(8'd100),
    .TIMEOUT  (32'd2000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample      (sample),
    .sample_valid(sample_valid),
    .period      (period),
    .amp_pp      (amp_pp),
    .period_valid(period_valid),
    .locked      (locked),
    .signal_lost (signal_lost)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every period_valid pulse must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (period_valid === 1'b1) begin
      pulses++;
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got period=%0d amp=%0d expected no pulse", period, amp_pp);
      end else begin
        e = expq.pop_front();
        chk("pulse_period", period, e.period);
        chk("pulse_amp", {24'd0, amp_pp}, {24'd0, e.amp});
        chk("pulse_locked", {31'd0, locked}, 32'd1);
        chk("pulse_signal_lost", {31'd0, signal_lost}, 32'd0);
      end
    end
  end

  task automatic drive(input logic v, input logic [7:0] s);
    sample       = s;
    sample_valid = v;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic logic [7:0] stair(input int i);
    if (i < 8)       return 8'(30 * (i + 1));
    else if (i < 15) return 8'(240 - 30 * (i - 7));
    else             return 8'd0;
  endfunction

  // Staircase 30..240..30,0, 64 cycles per step. The first valid cycle of the
  // 150 step (index 4) is the crossing; a pulse is expected once NEED raw
  // measurements exist in the current chain.
  task automatic run_stair(input int reps, input bit gapped, input int stop_after);
    bit   crossed;
    bit   v;
    exp_t e;
    crossed = 1'b0;
    for (int r = 0; r < reps; r++) begin
      for (int st = 0; st < 16; st++) begin
        for (int j = 0; j < 64; j++) begin
          v = !gapped || (j % 2 == 0);
          if (v && st == 4 && j == 0) begin
            chain++;
            if (chain - 1 >= NEED) begin
              e.period = 32'd1024;
              e.amp    = 8'd240;
              expq.push_back(e);
            end
          end
          drive(v, stair(st));
          if (v && st == 4 && j == 0) begin
            last_cross = cyc;
            crossed    = 1'b1;
          end
          if (crossed && stop_after >= 0 && (cyc - last_cross) == stop_after) return;
        end
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) drive(1'b0, 8'd0);
    reset = 1'b0;
    chain = 0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_period"}, period, 32'd0);
    chk({tag, "_amp"}, {24'd0, amp_pp}, 32'd0);
    chk({tag, "_period_valid"}, {31'd0, period_valid}, 32'd0);
    chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
    chk({tag, "_signal_lost"}, {31'd0, signal_lost}, 32'd0);
  endtask

  initial begin
    int p0;
    int el;
    reset        = 1'b1;
    sample       = 8'd0;
    sample_valid = 1'b0;

    do_reset(3);
    check_reset("init");

    // Hysteresis: 120/150 never reaches THRESH_LO, so never arms. Runs past
    // TIMEOUT to confirm an idle HUNT with no reference does not time out.
    for (int k = 0; k < 2400; k++) drive(1'b1, ((k / 10) % 2 == 0) ? 8'd120 : 8'd150);
    chk("hyst_pulses", pulses, 32'd0);
    chk("hyst_locked", {31'd0, locked}, 32'd0);
    chk("hyst_no_timeout", {31'd0, signal_lost}, 32'd0);

    // Staircase lock
    do_reset(2);
    check_reset("pre_stair");
    run_stair(1, 1'b0, -1);
    chk("first_cross_no_lock", {31'd0, locked}, 32'd0);
    p0 = pulses;
    run_stair(NEED + 1, 1'b0, -1);
    chk("stair_locked", {31'd0, locked}, 32'd1);
    chk("stair_pulse_count", pulses - p0, 32'd2);

    // Timeout: hold 0 after the last crossing
    el = cyc - last_cross;
    while (el < TO + 40) begin
      drive(1'b1, 8'd0);
      el = cyc - last_cross;
      if (el == TO - 1) begin
        chk("pre_timeout_lost", {31'd0, signal_lost}, 32'd0);
        chk("pre_timeout_locked", {31'd0, locked}, 32'd1);
      end
      if (el == TO) begin
        chk("timeout_lost", {31'd0, signal_lost}, 32'd1);
        chk("timeout_locked", {31'd0, locked}, 32'd0);
        chk("timeout_period_held", period, 32'd1024);
        chk("timeout_amp_held", {24'd0, amp_pp}, 32'd240);
        chain = 0;
      end
    end
    run_stair(1, 1'b0, -1);
    chk("lost_held", {31'd0, signal_lost}, 32'd1);
    chk("relock_not_yet", {31'd0, locked}, 32'd0);
    run_stair(NEED, 1'b0, -1);
    chk("lost_cleared", {31'd0, signal_lost}, 32'd0);
    chk("relocked", {31'd0, locked}, 32'd1);

    // Gapped valid
    do_reset(1);
    p0 = pulses;
    run_stair(NEED + 2, 1'b1, -1);
    chk("gapped_locked", {31'd0, locked}, 32'd1);
    chk("gapped_pulse_count", pulses - p0, 32'd2);

    // Mid-run reset 300 cycles after a crossing
    do_reset(1);
    run_stair(NEED + 1, 1'b0, -1);
    run_stair(1, 1'b0, 300);
    do_reset(1);
    check_reset("midrun");
    p0 = pulses;
    run_stair(2, 1'b0, -1);
    chk("midrun_pulse_count", pulses - p0, (NEED == 1) ? 32'd1 : 32'd0);

    repeat (4) drive(1'b0, 8'd0);
    chk("queue_drained", expq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
